dds_wave_gen: RTL and testbench



---
 rtl/dds_pkg.sv | 16 +
 rtl/dds_sine_lut.sv | 48 ++++
 rtl/dds_wave_gen.sv | 152 +++++++++++++++
 tb/tb_dds_wave_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths, mode encoding and types for the dds_wave_gen block.
// The optional sine LUT is selected at build time with the DDS_SINE_EN macro.
package dds_pkg;

    localparam int unsigned DDS_ACC_W   = 32;
    localparam int unsigned DDS_PHASE_W = 11;
    localparam int unsigned DDS_OUT_W   = 10;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SINE   = 2'd0;
    localparam mode_t MODE_SQUARE = 2'd1;
    localparam mode_t MODE_SAW    = 2'd2;
    localparam mode_t MODE_TRI    = 2'd3;

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine ROM with a registered one-cycle read (pipeline stage S2).
// Only instantiated when DDS_SINE_EN is defined.
module dds_sine_lut #(
    parameter int unsigned PHASE_W = 11,
    parameter int unsigned OUT_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-3:0] addr,
    output logic [OUT_W-2:0]   data
);

    localparam int unsigned DEPTH   = 2 ** (PHASE_W - 2);
    localparam real         AMP     = real'((2 ** (OUT_W - 1)) - 1);
    localparam real         HALF_PI = 1.5707963267948966;

    // Entries sample the centre of each quarter-wave bin so the fold is symmetric.
    function automatic logic [OUT_W-2:0] lut_entry(input int idx);
        real x;
        x = AMP * $sin(HALF_PI * (real'(idx) + 0.5) / real'(DEPTH));
        return (OUT_W - 1)'($rtoi(x + 0.5));
    endfunction

    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [OUT_W-2:0] ENTRY = lut_entry(i);
        assign rom[i] = ENTRY;
    end

    logic [OUT_W-2:0] data_d;
    logic [OUT_W-2:0] data_q;

    always_comb begin
        data_d = rom[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/dds_wave_gen.sv
// Multi-waveform DDS: phase accumulator, double-buffered controls and a 3-stage output pipeline.
// Define DDS_SINE_EN to build the quarter-wave sine LUT; otherwise mode 0 produces triangle.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W   = DDS_ACC_W,
    parameter int unsigned PHASE_W = DDS_PHASE_W,
    parameter int unsigned OUT_W   = DDS_OUT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [ACC_W-1:0]   freq_word,
    input  logic [PHASE_W-1:0] phase_off,
    input  mode_t              mode,
    input  logic               sync_clr,
    output logic [OUT_W-1:0]   wave_out,
    output logic               out_valid,
    output logic               wrap
);

    // Accumulator and active control registers
    logic [ACC_W-1:0]   acc_d,    acc_q;
    logic [ACC_W-1:0]   r_k_d,    r_k_q;
    logic [PHASE_W-1:0] r_p_d,    r_p_q;
    mode_t              r_mode_d, r_mode_q;
    logic               wrap_d,   wrap_q;
    logic               en0_d,    en0_q;
    logic [ACC_W:0]     sum;

    // Pipeline stages S1..S3
    logic [PHASE_W-1:0] ph1_d,    ph1_q;
    mode_t              mode1_d,  mode1_q;
    logic               vld1_d,   vld1_q;
    logic [OUT_W-1:0]   raw2_d,   raw2_q;
    logic               vld2_d,   vld2_q;
    logic [OUT_W-1:0]   wave_d,   wave_q;
    logic               valid_d,  valid_q;
    logic [PHASE_W-2:0] tri_fold;

`ifdef DDS_SINE_EN
    localparam logic [OUT_W-1:0] HALF    = {1'b1, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0] HALF_M1 = {1'b0, {(OUT_W - 1){1'b1}}};

    mode_t              mode2_d,  mode2_q;
    logic               fold2_d,  fold2_q;
    logic [PHASE_W-3:0] lut_addr;
    logic [OUT_W-2:0]   lut_data;

    dds_sine_lut #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_sine_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (lut_addr),
        .data (lut_data)
    );
`endif

    // Accumulator step; sync_clr overrides en and never reports a wrap
    always_comb begin
        acc_d    = acc_q;
        wrap_d   = 1'b0;
        r_k_d    = r_k_q;
        r_p_d    = r_p_q;
        r_mode_d = r_mode_q;
        en0_d    = en;
        sum      = {1'b0, acc_q} + {1'b0, r_k_q};
        if (sync_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = sum[ACC_W];
        end
        if (load) begin
            r_k_d    = freq_word;
            r_p_d    = phase_off;
            r_mode_d = mode;
        end
    end

    // Phase code, per-mode shaping and sine fold; mode travels with its phase code
    always_comb begin
        ph1_d    = acc_q[ACC_W-1 -: PHASE_W] + r_p_q;
        mode1_d  = r_mode_q;
        vld1_d   = en0_q;
        vld2_d   = vld1_q;
        valid_d  = vld2_q;
        tri_fold = ph1_q[PHASE_W-1] ? ~ph1_q[PHASE_W-2:0] : ph1_q[PHASE_W-2:0];
        case (mode1_q)
            MODE_SQUARE: raw2_d = {OUT_W{~ph1_q[PHASE_W-1]}};
            MODE_SAW:    raw2_d = ph1_q[PHASE_W-1 -: OUT_W];
            default:     raw2_d = tri_fold[PHASE_W-2 -: OUT_W];
        endcase
        wave_d = raw2_q;
`ifdef DDS_SINE_EN
        mode2_d  = mode1_q;
        fold2_d  = ph1_q[PHASE_W-1];
        lut_addr = ph1_q[PHASE_W-2] ? ~ph1_q[PHASE_W-3:0] : ph1_q[PHASE_W-3:0];
        if (mode2_q == MODE_SINE) begin
            wave_d = fold2_q ? (HALF_M1 - {1'b0, lut_data}) : (HALF + {1'b0, lut_data});
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            r_k_q    <= '0;
            r_p_q    <= '0;
            r_mode_q <= MODE_SINE;
            wrap_q   <= 1'b0;
            en0_q    <= 1'b0;
            ph1_q    <= '0;
            mode1_q  <= MODE_SINE;
            vld1_q   <= 1'b0;
            raw2_q   <= '0;
            vld2_q   <= 1'b0;
            wave_q   <= '0;
            valid_q  <= 1'b0;
`ifdef DDS_SINE_EN
            mode2_q  <= MODE_SINE;
            fold2_q  <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            r_k_q    <= r_k_d;
            r_p_q    <= r_p_d;
            r_mode_q <= r_mode_d;
            wrap_q   <= wrap_d;
            en0_q    <= en0_d;
            ph1_q    <= ph1_d;
            mode1_q  <= mode1_d;
            vld1_q   <= vld1_d;
            raw2_q   <= raw2_d;
            vld2_q   <= vld2_d;
            wave_q   <= wave_d;
            valid_q  <= valid_d;
`ifdef DDS_SINE_EN
            mode2_q  <= mode2_d;
            fold2_q  <= fold2_d;
`endif
        end
    end

    assign wave_out  = wave_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: spot-value table, corner sequences and a
// randomized run against a sample-level reference model (honours DDS_SINE_EN).
module tb_dds_wave_gen;
    import dds_pkg::*;

    localparam int ACC_W   = 32;
    localparam int PHASE_W = 11;
    localparam int OUT_W   = 10;
    localparam int PH_N    = 2 ** PHASE_W;
    localparam int QTR     = PH_N / 4;
    localparam int OUT_N   = 2 ** OUT_W;
    localparam int HALF    = OUT_N / 2;
    localparam real AMP    = real'(HALF - 1);
    localparam real PI     = 3.14159265358979323846;

`ifdef DDS_SINE_EN
    localparam int W_PH0 = 513, W_PH512 = 1023, W_PH1024 = 510, W_PH1536 = 0;
`else
    localparam int W_PH0 = 0, W_PH512 = 512, W_PH1024 = 1023, W_PH1536 = 511;
`endif

    logic               clk = 1'b0;
    logic               rst, en, load, sync_clr;
    logic [ACC_W-1:0]   freq_word;
    logic [PHASE_W-1:0] phase_off;
    mode_t              mode;
    logic [OUT_W-1:0]   wave_out;
    logic               out_valid, wrap;

    always #5 clk = ~clk;

    dds_wave_gen dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .freq_word (freq_word),
        .phase_off (phase_off),
        .mode      (mode),
        .sync_clr  (sync_clr),
        .wave_out  (wave_out),
        .out_valid (out_valid),
        .wrap      (wrap)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit known;
        int wave;
        bit valid;
    } exp_t;

    typedef struct {
        mode_t            md;
        logic [ACC_W-1:0] k;
        logic [PHASE_W-1:0] p;
        int               steps;
        int               exp_wave;
    } vec_t;

    // Reference state: accumulator, active controls and expected samples in flight
    logic [ACC_W-1:0]   m_acc = '0;
    logic [ACC_W-1:0]   m_k = '0;
    logic [PHASE_W-1:0] m_p = '0;
    int                 m_mode = 0;
    bit                 exp_wrap = 1'b0;
    exp_t               cur_exp = '{1'b0, 0, 1'b0};
    exp_t               hist[3];

    function automatic int wave_of(logic [ACC_W-1:0] acc, logic [PHASE_W-1:0] p, int md);
        int ph, q, a, res;
        real v;
        ph = (int'(acc >> (ACC_W - PHASE_W)) + int'(p)) % PH_N;
`ifndef DDS_SINE_EN
        if (md == 0) md = 3;
`endif
        case (md)
            0: begin
                q = ph / QTR;
                a = ph % QTR;
                if (q % 2 == 1) a = QTR - 1 - a;
                v = $floor(AMP * $sin(PI / 2.0 * (real'(a) + 0.5) / real'(QTR)) + 0.5);
                res = (q >= 2) ? (HALF - 1 - int'(v)) : (HALF + int'(v));
            end
            1: res = (ph < PH_N / 2) ? (OUT_N - 1) : 0;
            2: res = ph / (2 ** (PHASE_W - OUT_W));
            default: begin
                a = (ph < PH_N / 2) ? ph : (PH_N - 1 - ph);
                res = a / (2 ** (PHASE_W - 1 - OUT_W));
            end
        endcase
        return res;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit l, input bit s,
                         input logic [ACC_W-1:0] k, input logic [PHASE_W-1:0] p, input mode_t m);
        rst = r; en = e; load = l; sync_clr = s;
        freq_word = k; phase_off = p; mode = m;
    endtask

    // One clock edge: advance the model, then compare outputs just after the edge
    task automatic tick();
        longint s;
        @(posedge clk);
        s = longint'(m_acc) + longint'(m_k);
        if (rst) begin
            m_acc = '0; m_k = '0; m_p = '0; m_mode = 0;
            exp_wrap = 1'b0;
            cur_exp = '{1'b1, 0, 1'b0};
            hist[2] = '{1'b0, 0, 1'b0};
            hist[1] = '{1'b1, wave_of('0, '0, 0), 1'b0};
            hist[0] = hist[1];
        end else begin
            exp_wrap = en && !sync_clr && (s >= 64'h1_0000_0000);
            if (sync_clr) m_acc = '0;
            else if (en) m_acc = s[ACC_W-1:0];
            if (load) begin
                m_k = freq_word; m_p = phase_off; m_mode = int'(mode);
            end
            cur_exp = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = '{1'b1, wave_of(m_acc, m_p, m_mode), en};
        end
        #1;
        check("out_valid", int'(out_valid), int'(cur_exp.valid));
        check("wrap", int'(wrap), int'(exp_wrap));
        if (cur_exp.known) check("wave_out", int'(wave_out), cur_exp.wave);
    endtask

    initial begin
        vec_t vecs[16];
        int   wv[8];
        int   wr[8];
        int   nwrap, first_wrap, last_wrap, w2, w3;

        hist[0] = '{1'b0, 0, 1'b0};
        hist[1] = hist[0];
        hist[2] = hist[0];

        vecs[0]  = '{MODE_SAW,    32'h0100_0000, 11'd0,    5,   20};
        vecs[1]  = '{MODE_SAW,    32'h0100_0000, 11'd0,    255, 1020};
        vecs[2]  = '{MODE_SAW,    32'h0100_0000, 11'd0,    256, 0};
        vecs[3]  = '{MODE_SQUARE, 32'h0800_0000, 11'd0,    15,  1023};
        vecs[4]  = '{MODE_SQUARE, 32'h0800_0000, 11'd0,    16,  0};
        vecs[5]  = '{MODE_SQUARE, 32'h0800_0000, 11'd1024, 0,   0};
        vecs[6]  = '{MODE_TRI,    32'h0100_0000, 11'd0,    100, 800};
        vecs[7]  = '{MODE_TRI,    32'h0100_0000, 11'd0,    200, 447};
        vecs[8]  = '{MODE_SAW,    32'h0100_0000, 11'd3,    0,   1};
        vecs[9]  = '{MODE_SINE,   32'h0800_0000, 11'd0,    8,   W_PH512};
        vecs[10] = '{MODE_SINE,   32'h0800_0000, 11'd0,    24,  W_PH1536};
        vecs[11] = '{MODE_SINE,   32'h0800_0000, 11'd0,    0,   W_PH0};
        vecs[12] = '{MODE_SINE,   32'h0800_0000, 11'd0,    16,  W_PH1024};
        vecs[13] = '{MODE_SQUARE, 32'h0000_0000, 11'd2047, 0,   0};
        vecs[14] = '{MODE_SAW,    32'hFFFF_FFFF, 11'd0,    1,   1023};
        vecs[15] = '{MODE_TRI,    32'h0010_0000, 11'd0,    3,   1};

        // Reset held two cycles with random inputs, then released with en=1
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                  11'($urandom), 2'($urandom_range(3)));
            tick();
            check("rst_wave", int'(wave_out), 0);
            check("rst_valid", int'(out_valid), 0);
            check("rst_wrap", int'(wrap), 0);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, MODE_SINE);
            tick();
            check($sformatf("valid_rise_%0d", i), int'(out_valid), (i == 4) ? 1 : 0);
        end

        // Spot values: clear+load, n enabled steps, then let the pipeline settle
        foreach (vecs[i]) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, vecs[i].k, vecs[i].p, vecs[i].md);
            tick();
            for (int s = 0; s < vecs[i].steps; s++) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, vecs[i].k, vecs[i].p, vecs[i].md);
                tick();
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0, vecs[i].k, vecs[i].p, vecs[i].md);
            repeat (4) tick();
            check($sformatf("vec%0d", i), int'(wave_out), vecs[i].exp_wave);
        end

        // Sawtooth wrap cadence: one pulse every 256 steps at K=2^24
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0100_0000, '0, MODE_SAW);
        tick();
        nwrap = 0; first_wrap = -1; last_wrap = -1;
        for (int i = 1; i <= 512; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0100_0000, '0, MODE_SAW);
            tick();
            if (wrap) begin
                nwrap++;
                if (first_wrap < 0) first_wrap = i;
                last_wrap = i;
            end
        end
        check("wrap_count", nwrap, 2);
        check("wrap_period", last_wrap - first_wrap, 256);

        // Square inverts exactly 3 edges after a phase-offset load
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0800_0000, '0, MODE_SQUARE);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0800_0000, '0, MODE_SQUARE);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0800_0000, 11'd1024, MODE_SQUARE);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0800_0000, 11'd1024, MODE_SQUARE);
        tick();
        tick();
        w2 = int'(wave_out);
        tick();
        w3 = int'(wave_out);
        check("sq_before_invert", w2, 1023);
        check("sq_after_invert", w3, 0);

        // sync_clr together with a load of K=0x4000_0000, mid-stream
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0123_4567, 11'd77, MODE_SAW);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0123_4567, 11'd77, MODE_SAW);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000, '0, MODE_SAW);
        tick();
        check("clr_no_wrap", int'(wrap), 0);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, '0, MODE_SAW);
            tick();
            wv[i] = int'(wave_out);
            wr[i] = int'(wrap);
        end
        check("clr_w3", wv[3], 0);
        check("clr_w4", wv[4], 256);
        check("clr_w5", wv[5], 512);
        check("clr_w6", wv[6], 768);
        check("clr_w7", wv[7], 0);
        check("clr_wrap3", wr[3], 0);
        check("clr_wrap4", wr[4], 1);

        // Reset mid-sine: outputs clear, then static mode-0 sample at phase 0
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0800_0000, 11'd300, MODE_SINE);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0800_0000, 11'd300, MODE_SINE);
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0800_0000, 11'd300, MODE_SINE);
        tick();
        check("midrst_wave", int'(wave_out), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_wrap", int'(wrap), 0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0800_0000, 11'd300, MODE_SINE);
            tick();
            if (i >= 3) check($sformatf("midrst_static_%0d", i), int'(wave_out), W_PH0);
            if (i == 4) check("midrst_valid_back", int'(out_valid), 1);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(149) == 0), ($urandom_range(3) != 0),
                  ($urandom_range(29) == 0), ($urandom_range(49) == 0),
                  ($urandom_range(1) == 0) ? $urandom : ($urandom >> 6),
                  11'($urandom), 2'($urandom_range(3)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
